// File: rtl/memctrl_pkg.sv
// Shared types and constants for the byte-wide RAM port controller.
// Holds the FSM encoding, the access size codes and the IO window placement.
package memctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_e;

  typedef enum logic {
    REQ_IC  = 1'b0,
    REQ_LSB = 1'b1
  } req_e;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  localparam logic [31:0] IO_BASE_DEFAULT = 32'h0003_0000;
  localparam int          IO_SPAN         = 8;

  // Number of byte transfers for an LSB access size.
  function automatic logic [2:0] size_to_n(input logic [1:0] size);
    case (size)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/memctrl_arbiter.sv
// Two-way round-robin grant between icache and LSB.
// A requester whose done pulse is high this cycle is masked so it is not re-accepted.
module rr_arbiter2
  import memctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic rdy,
  input  logic idle,
  input  logic clear,
  input  logic req_ic,
  input  logic req_lsb,
  input  logic done_ic,
  input  logic done_lsb,
  output logic grant_ic,
  output logic grant_lsb
);

  req_e last_grant;
  logic open;
  logic ic_ok;
  logic lsb_ok;

  assign open   = rdy & idle & ~clear;
  assign ic_ok  = req_ic & ~done_ic;
  assign lsb_ok = req_lsb & ~done_lsb;

  // On a tie the requester that was not served last wins.
  assign grant_ic  = open & ic_ok  & (~lsb_ok | (last_grant == REQ_LSB));
  assign grant_lsb = open & lsb_ok & (~ic_ok  | (last_grant == REQ_IC));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= REQ_LSB;
    end else if (grant_ic) begin
      last_grant <= REQ_IC;
    end else if (grant_lsb) begin
      last_grant <= REQ_LSB;
    end
  end

endmodule

// File: rtl/memctrl.sv
// Byte-wide RAM port controller shared by the icache and the load/store buffer.
// Splits requests into 1/2/4 byte transfers and assembles read data little-endian.
module memctrl
  import memctrl_pkg::*;
#(
  parameter int                ADDR_W  = 32,
  parameter logic [ADDR_W-1:0] IO_BASE = ADDR_W'(IO_BASE_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full,
  input  logic              clear,
  input  logic              icache_to_memctrl,
  input  logic [ADDR_W-1:0] icache_addr,
  output logic              memctrl_to_icache,
  output logic [31:0]       inst_out,
  input  logic              lsb_to_memctrl,
  input  logic              lsb_wr,
  input  logic [1:0]        lsb_size,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  output logic              memctrl_to_lsb,
  output logic [31:0]       lsb_rdata
);

  state_e            state, state_next;
  req_e              owner, owner_next;
  logic [ADDR_W-1:0] base_addr, base_addr_next;
  logic [2:0]        n_bytes, n_bytes_next;
  logic [2:0]        a_idx, a_idx_next;
  logic              pend_valid, pend_valid_next;
  logic [1:0]        pend_idx, pend_idx_next;
  logic [31:0]       data_buf, data_buf_next;
  logic [31:0]       wdata, wdata_next;
  logic [ADDR_W-1:0] mem_a_q, mem_a_next;
  logic [7:0]        dout_q, dout_next;
  logic              wr_q, wr_next;
  logic              ic_done, ic_done_next;
  logic              lsb_done, lsb_done_next;
  logic [31:0]       inst_q, inst_next;
  logic [31:0]       rdata_q, rdata_next;

  logic              grant_ic;
  logic              grant_lsb;
  logic [31:0]       buf_cap;
  logic [2:0]        a_idx_inc;
  logic [1:0]        wr_sel;
  logic [ADDR_W-1:0] io_off;
  logic              io_hit;
  logic              throttle;

  rr_arbiter2 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .rdy       (rdy),
    .idle      (state == ST_IDLE),
    .clear     (clear),
    .req_ic    (icache_to_memctrl),
    .req_lsb   (lsb_to_memctrl),
    .done_ic   (ic_done),
    .done_lsb  (lsb_done),
    .grant_ic  (grant_ic),
    .grant_lsb (grant_lsb)
  );

  // Buffer with the byte arriving on mem_din merged into its lane.
  for (genvar gi = 0; gi < 4; gi++) begin : g_cap
    assign buf_cap[8*gi +: 8] = (pend_idx == 2'(gi)) ? mem_din : data_buf[8*gi +: 8];
  end

  assign a_idx_inc = a_idx + 3'd1;
  assign wr_sel    = a_idx_inc[1:0];
  assign io_off    = base_addr - IO_BASE;
  assign io_hit    = io_off < ADDR_W'(IO_SPAN);
  assign throttle  = (state == ST_WRITE) && io_hit && io_buffer_full;

  assign mem_a             = mem_a_q;
  assign mem_dout          = dout_q;
  assign mem_wr            = wr_q & rdy & ~throttle;
  assign memctrl_to_icache = ic_done;
  assign memctrl_to_lsb    = lsb_done;
  assign inst_out          = inst_q;
  assign lsb_rdata         = rdata_q;

  always_comb begin
    state_next      = state;
    owner_next      = owner;
    base_addr_next  = base_addr;
    n_bytes_next    = n_bytes;
    a_idx_next      = a_idx;
    pend_valid_next = pend_valid;
    pend_idx_next   = pend_idx;
    data_buf_next   = data_buf;
    wdata_next      = wdata;
    mem_a_next      = mem_a_q;
    dout_next       = dout_q;
    wr_next         = wr_q;
    ic_done_next    = ic_done;
    lsb_done_next   = lsb_done;
    inst_next       = inst_q;
    rdata_next      = rdata_q;

    if (!rdy) begin
      // A byte in flight during a pause is lost; rewind so it is re-presented.
      if (state == ST_READ && pend_valid) begin
        a_idx_next = {1'b0, pend_idx};
        mem_a_next = base_addr + ADDR_W'(pend_idx);
      end
      pend_valid_next = 1'b0;
    end else begin
      ic_done_next  = 1'b0;
      lsb_done_next = 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant_ic || grant_lsb) begin
            base_addr_next  = grant_ic ? icache_addr : lsb_addr;
            mem_a_next      = grant_ic ? icache_addr : lsb_addr;
            owner_next      = grant_ic ? REQ_IC : REQ_LSB;
            n_bytes_next    = grant_ic ? 3'd4 : size_to_n(lsb_size);
            a_idx_next      = 3'd0;
            pend_valid_next = 1'b0;
            data_buf_next   = 32'd0;
            if (grant_lsb && lsb_wr) begin
              state_next = ST_WRITE;
              wr_next    = 1'b1;
              wdata_next = lsb_wdata;
              dout_next  = lsb_wdata[7:0];
            end else begin
              state_next = ST_READ;
            end
          end
        end

        ST_READ: begin
          if (clear) begin
            state_next      = ST_IDLE;
            mem_a_next      = '0;
            pend_valid_next = 1'b0;
          end else begin
            if (pend_valid) begin
              data_buf_next = buf_cap;
              if ({1'b0, pend_idx} == n_bytes - 3'd1) begin
                state_next = ST_IDLE;
                mem_a_next = '0;
                if (owner == REQ_IC) begin
                  inst_next    = buf_cap;
                  ic_done_next = 1'b1;
                end else begin
                  rdata_next    = buf_cap;
                  lsb_done_next = 1'b1;
                end
              end
            end
            if (a_idx < n_bytes) begin
              pend_valid_next = 1'b1;
              pend_idx_next   = a_idx[1:0];
              a_idx_next      = a_idx_inc;
              mem_a_next      = (a_idx_inc < n_bytes) ? base_addr + ADDR_W'(a_idx_inc) : '0;
            end else begin
              pend_valid_next = 1'b0;
            end
          end
        end

        ST_WRITE: begin
          if (!throttle) begin
            if (a_idx == n_bytes - 3'd1) begin
              state_next    = ST_IDLE;
              mem_a_next    = '0;
              wr_next       = 1'b0;
              dout_next     = 8'd0;
              lsb_done_next = 1'b1;
            end else begin
              a_idx_next = a_idx_inc;
              mem_a_next = base_addr + ADDR_W'(a_idx_inc);
              dout_next  = wdata[{wr_sel, 3'b000} +: 8];
            end
          end
        end

        default: begin
          state_next = ST_IDLE;
          mem_a_next = '0;
          wr_next    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      owner      <= REQ_IC;
      base_addr  <= '0;
      n_bytes    <= 3'd0;
      a_idx      <= 3'd0;
      pend_valid <= 1'b0;
      pend_idx   <= 2'd0;
      data_buf   <= 32'd0;
      wdata      <= 32'd0;
      mem_a_q    <= '0;
      dout_q     <= 8'd0;
      wr_q       <= 1'b0;
      ic_done    <= 1'b0;
      lsb_done   <= 1'b0;
      inst_q     <= 32'd0;
      rdata_q    <= 32'd0;
    end else begin
      state      <= state_next;
      owner      <= owner_next;
      base_addr  <= base_addr_next;
      n_bytes    <= n_bytes_next;
      a_idx      <= a_idx_next;
      pend_valid <= pend_valid_next;
      pend_idx   <= pend_idx_next;
      data_buf   <= data_buf_next;
      wdata      <= wdata_next;
      mem_a_q    <= mem_a_next;
      dout_q     <= dout_next;
      wr_q       <= wr_next;
      ic_done    <= ic_done_next;
      lsb_done   <= lsb_done_next;
      inst_q     <= inst_next;
      rdata_q    <= rdata_next;
    end
  end

endmodule

// File: tb/tb_memctrl.sv
// Directed and randomized checks of memctrl against a byte-array memory model.
// Expected data comes from ref_mem, updated by the bench whenever it issues a store.
module tb_memctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  logic        clear;
  logic        icache_to_memctrl;
  logic [31:0] icache_addr;
  logic        memctrl_to_icache;
  logic [31:0] inst_out;
  logic        lsb_to_memctrl;
  logic        lsb_wr;
  logic [1:0]  lsb_size;
  logic [31:0] lsb_addr;
  logic [31:0] lsb_wdata;
  logic        memctrl_to_lsb;
  logic [31:0] lsb_rdata;

  logic [7:0]  ram     [0:4095];
  logic [7:0]  ref_mem [0:4095];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] ic_exp;
  logic [31:0] lsb_exp;
  logic        lsb_is_wr;
  logic [31:0] lsb_a;
  int          lsb_n;

  memctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rdy               (rdy),
    .mem_din           (mem_din),
    .mem_dout          (mem_dout),
    .mem_a             (mem_a),
    .mem_wr            (mem_wr),
    .io_buffer_full    (io_buffer_full),
    .clear             (clear),
    .icache_to_memctrl (icache_to_memctrl),
    .icache_addr       (icache_addr),
    .memctrl_to_icache (memctrl_to_icache),
    .inst_out          (inst_out),
    .lsb_to_memctrl    (lsb_to_memctrl),
    .lsb_wr            (lsb_wr),
    .lsb_size          (lsb_size),
    .lsb_addr          (lsb_addr),
    .lsb_wdata         (lsb_wdata),
    .memctrl_to_lsb    (memctrl_to_lsb),
    .lsb_rdata         (lsb_rdata)
  );

  always #5 clk = ~clk;

  // RAM: read data follows the address of the previous cycle; 4 KB aliased.
  always @(posedge clk) begin
    mem_din <= ram[mem_a[11:0]];
    if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int nb);
    logic [31:0] v;
    v = 32'd0;
    for (int i = 0; i < nb; i++) v = v + (32'(ref_mem[(a + i) & 32'hFFF]) << (8 * i));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input int nb, input logic [31:0] d);
    for (int i = 0; i < nb; i++) ref_mem[(a + i) & 32'hFFF] = d[8*i +: 8];
  endtask

  task automatic issue_lsb(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                           input logic [31:0] d);
    lsb_n     = 1 << sz;
    lsb_a     = a;
    lsb_is_wr = wr;
    lsb_wr    = wr;
    lsb_size  = sz;
    lsb_addr  = a;
    lsb_wdata = d;
    if (wr) ref_store(a, lsb_n, d);
    else    lsb_exp = ref_load(a, lsb_n);
    lsb_to_memctrl = 1'b1;
  endtask

  task automatic check_store_bytes();
    for (int i = 0; i < lsb_n; i++)
      chk("st_byte", 32'(ram[(lsb_a + i) & 32'hFFF]), 32'(ref_mem[(lsb_a + i) & 32'hFFF]));
  endtask

  // Step until every outstanding request has seen its done pulse.
  task automatic service(input int bound);
    int k;
    k = 0;
    while ((icache_to_memctrl || lsb_to_memctrl) && k < bound) begin
      step();
      k++;
      if (memctrl_to_icache) begin
        chk("ic_word", inst_out, ic_exp);
        $display("txn icache fetch data=%h", inst_out);
        icache_to_memctrl = 1'b0;
      end
      if (memctrl_to_lsb) begin
        if (lsb_is_wr) check_store_bytes();
        else chk("lsb_load", lsb_rdata, lsb_exp);
        $display("txn lsb %s addr=%h n=%0d rdata=%h", lsb_is_wr ? "store" : "load",
                 lsb_a, lsb_n, lsb_rdata);
        lsb_to_memctrl = 1'b0;
      end
    end
    chk("service_done", 32'(icache_to_memctrl | lsb_to_memctrl), 32'd0);
    icache_to_memctrl = 1'b0;
    lsb_to_memctrl    = 1'b0;
  endtask

  initial begin
    int          cyc;
    logic        do_ic;
    logic        do_lsb;
    logic [1:0]  sz;
    logic        wr;
    logic [31:0] a;
    logic [31:0] wd;

    rst_n = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0; clear = 1'b0;
    icache_to_memctrl = 1'b0; icache_addr = 32'd0;
    lsb_to_memctrl = 1'b0; lsb_wr = 1'b0; lsb_size = 2'b00; lsb_addr = 32'd0; lsb_wdata = 32'd0;
    lsb_is_wr = 1'b0; lsb_a = 32'd0; lsb_n = 1; ic_exp = 32'd0; lsb_exp = 32'd0;

    for (int i = 0; i < 4096; i++) begin
      ram[i]     = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    begin
      logic [7:0] init_bytes [0:7];
      init_bytes = '{8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h08, 8'h10, 8'h00};
      for (int i = 0; i < 8; i++) begin
        ram[32'h100 + i]     = init_bytes[i];
        ref_mem[32'h100 + i] = init_bytes[i];
      end
    end

    // Reset state
    step(); step();
    chk("rst_mem_wr", 32'(mem_wr), 32'd0);
    chk("rst_mem_a", mem_a, 32'd0);
    chk("rst_mem_dout", 32'(mem_dout), 32'd0);
    chk("rst_ic_done", 32'(memctrl_to_icache), 32'd0);
    chk("rst_lsb_done", 32'(memctrl_to_lsb), 32'd0);
    chk("rst_inst_out", inst_out, 32'd0);
    chk("rst_lsb_rdata", lsb_rdata, 32'd0);
    rst_n = 1'b1;
    step();

    // Tie right after reset: icache first, LSB in the icache done cycle
    icache_addr = 32'h100; ic_exp = ref_load(32'h100, 4); icache_to_memctrl = 1'b1;
    issue_lsb(1'b0, 2'b01, 32'h100, 32'd0);
    for (int c = 1; c <= 4; c++) begin
      step();
      chk("tie_ic_addr", mem_a, 32'h100 + c - 1);
      chk("tie_ic_wr", 32'(mem_wr), 32'd0);
    end
    step();
    chk("ic_done_c5", 32'(memctrl_to_icache), 32'd0);
    step();
    chk("ic_done_c6", 32'(memctrl_to_icache), 32'd1);
    chk("ic_word_0513", inst_out, 32'h0000_0513);
    $display("txn icache fetch addr=00000100 data=%h", inst_out);
    icache_to_memctrl = 1'b0;
    step();
    chk("lsb_after_ic_addr", mem_a, 32'h100);
    chk("ic_pulse_1cyc", 32'(memctrl_to_icache), 32'd0);
    step();
    chk("lsb_addr_b1", mem_a, 32'h101);
    step();
    step();
    chk("lsb_done_c4", 32'(memctrl_to_lsb), 32'd1);
    chk("lsb_half_load", lsb_rdata, lsb_exp);
    $display("txn lsb load addr=00000100 n=2 rdata=%h", lsb_rdata);
    lsb_to_memctrl = 1'b0;
    step();
    chk("ic_hold", inst_out, 32'h0000_0513);

    // Next tie goes back to the icache
    icache_addr = 32'h104; ic_exp = ref_load(32'h104, 4); icache_to_memctrl = 1'b1;
    issue_lsb(1'b0, 2'b00, 32'h103, 32'd0);
    step();
    chk("tie2_ic_first", mem_a, 32'h104);
    service(40);
    step();

    // Half store 0xBEEF to 0x204, then read back a byte from 0x205
    issue_lsb(1'b1, 2'b01, 32'h204, 32'h1234_BEEF);
    step();
    chk("sth_a0", mem_a, 32'h204);
    chk("sth_d0", 32'(mem_dout), 32'hEF);
    chk("sth_wr0", 32'(mem_wr), 32'd1);
    step();
    chk("sth_a1", mem_a, 32'h205);
    chk("sth_d1", 32'(mem_dout), 32'hBE);
    chk("sth_wr1", 32'(mem_wr), 32'd1);
    step();
    chk("sth_done", 32'(memctrl_to_lsb), 32'd1);
    chk("sth_idle_wr", 32'(mem_wr), 32'd0);
    check_store_bytes();
    $display("txn lsb store addr=00000204 n=2 wdata=1234beef");
    lsb_to_memctrl = 1'b0;
    step();
    issue_lsb(1'b0, 2'b00, 32'h205, 32'd0);
    chk("ldb_ref", lsb_exp, 32'h0000_00BE);
    service(20);
    chk("ldb_be", lsb_rdata, 32'h0000_00BE);
    step();

    // clear in cycle 3 of a fetch aborts it; the waiting LSB load goes next
    icache_addr = 32'h108; ic_exp = 32'hFFFF_FFFF; icache_to_memctrl = 1'b1;
    step();
    issue_lsb(1'b0, 2'b10, 32'h104, 32'd0);
    step();
    step();
    clear = 1'b1; icache_to_memctrl = 1'b0;
    step();
    clear = 1'b0;
    chk("clr_no_done", 32'(memctrl_to_icache), 32'd0);
    chk("clr_idle_addr", mem_a, 32'd0);
    step();
    chk("clr_lsb_next", mem_a, 32'h104);
    chk("clr_no_done2", 32'(memctrl_to_icache), 32'd0);
    service(20);
    $display("txn icache fetch addr=00000108 aborted by clear");
    step();

    // clear during a word store is ignored
    wd = $urandom;
    issue_lsb(1'b1, 2'b10, 32'h210, wd);
    step();
    chk("stw_wr_c1", 32'(mem_wr), 32'd1);
    step();
    clear = 1'b1;
    chk("stw_a_c2", mem_a, 32'h211);
    step();
    clear = 1'b0;
    chk("stw_a_c3", mem_a, 32'h212);
    chk("stw_wr_c3", 32'(mem_wr), 32'd1);
    step();
    chk("stw_d_c4", 32'(mem_dout), 32'(wd[31:24]));
    step();
    chk("stw_done", 32'(memctrl_to_lsb), 32'd1);
    check_store_bytes();
    $display("txn lsb store addr=00000210 n=4 wdata=%h (clear ignored)", wd);
    lsb_to_memctrl = 1'b0;
    step();

    // IO store throttled for three cycles by io_buffer_full
    io_buffer_full = 1'b1;
    issue_lsb(1'b1, 2'b00, 32'h0003_0000, 32'h0000_0041);
    for (int c = 1; c <= 3; c++) begin
      step();
      chk("io_hold_wr", 32'(mem_wr), 32'd0);
      chk("io_hold_done", 32'(memctrl_to_lsb), 32'd0);
    end
    step();
    io_buffer_full = 1'b0;
    #1;
    chk("io_wr", 32'(mem_wr), 32'd1);
    chk("io_addr", mem_a, 32'h0003_0000);
    chk("io_data", 32'(mem_dout), 32'h41);
    step();
    chk("io_done", 32'(memctrl_to_lsb), 32'd1);
    chk("io_after_wr", 32'(mem_wr), 32'd0);
    check_store_bytes();
    $display("txn lsb store addr=00030000 n=1 wdata=41 (throttled 3)");
    lsb_to_memctrl = 1'b0;
    step();

    // rdy low for two cycles mid-fetch: done moves from cycle 6 to cycle 9
    icache_addr = 32'h100; ic_exp = ref_load(32'h100, 4); icache_to_memctrl = 1'b1;
    step(); step(); step();
    rdy = 1'b0;
    chk("pause_wr", 32'(mem_wr), 32'd0);
    step(); step();
    rdy = 1'b1;
    cyc = 5;
    while (!memctrl_to_icache && cyc < 20) begin
      step();
      cyc++;
    end
    chk("pause_done_cycle", 32'(cyc), 32'd9);
    chk("pause_word", inst_out, ic_exp);
    $display("txn icache fetch addr=00000100 data=%h done_cycle=%0d (paused)", inst_out, cyc);
    icache_to_memctrl = 1'b0;
    step();

    // Randomized mix of fetches, loads and stores
    for (int r = 0; r < 40; r++) begin
      do_ic  = 1'($urandom_range(0, 1));
      do_lsb = !do_ic || ($urandom_range(0, 3) != 0);
      if (do_ic) begin
        icache_addr = 32'h400 + ($urandom_range(0, 32'h3FF) & ~32'd3);
        ic_exp = ref_load(icache_addr, 4);
        icache_to_memctrl = 1'b1;
      end
      if (do_lsb) begin
        sz = 2'($urandom_range(0, 2));
        wr = 1'($urandom_range(0, 1));
        if (wr) a = 32'h800 + ($urandom_range(0, 32'h7FF) & ~((32'd1 << sz) - 1));
        else    a = 32'h400 + ($urandom_range(0, 32'hBFF) & ~((32'd1 << sz) - 1));
        issue_lsb(wr, sz, a, $urandom);
      end
      service(60);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/memctrl.md
Name: memctrl

Overview:
- Owns the single byte-wide RAM port. Shares it between the instruction cache (32-bit word fetch on miss) and the load/store buffer (byte, half or word loads and stores).
- Serialises each request into 1/2/4 byte transfers and assembles the result little-endian.
- Applies round-robin arbitration between the two requesters.
- Aborts speculative reads on pipeline clear and throttles stores to the IO window when the UART buffer is full.

Parameters:
- ADDR_W, 32, address width on all ports.
- IO_BASE, 32'h00030000, start of the 8-byte IO window; stores there obey io_buffer_full.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- rdy  input  1  global pause; low freezes all state
- mem_din  input  8  RAM read data; reflects the address driven in the previous cycle
- mem_dout  output  8  RAM write data
- mem_a  output  32  RAM byte address
- mem_wr  output  1  RAM write strobe, 1 = write
- io_buffer_full  input  1  UART FIFO full
- clear  input  1  pipeline flush (mispredict)
- icache_to_memctrl  input  1  icache request (level)
- icache_addr  input  32  word-aligned fetch address
- memctrl_to_icache  output  1  fetch done, 1-cycle pulse
- inst_out  output  32  fetched word, valid while done is high
- lsb_to_memctrl  input  1  LSB request (level)
- lsb_wr  input  1  1 = store
- lsb_size  input  2  00 byte, 01 half, 10 word
- lsb_addr  input  32  byte address; naturally aligned
- lsb_wdata  input  32  store data, low bytes first
- memctrl_to_lsb  output  1  load/store done, 1-cycle pulse
- lsb_rdata  output  32  load data, zero-extended

Behaviour:
- Reset (rst_n low, async):
  - state = IDLE, byte counter = 0.
  - mem_wr = 0, mem_a = 0, mem_dout = 0.
  - Both done outputs = 0; inst_out = 0, lsb_rdata = 0.
  - last_grant = LSB, so the icache wins the first tie.
- States: IDLE, READ, WRITE. N = byte count: 4 for icache; 1, 2 or 4 for the LSB.
- Requesters hold their request high until they see their done pulse. In the cycle a done pulse is high, the controller does not accept that same requester.
- Arbitration, evaluated in IDLE at edge E0:
  - One requester active: grant it.
  - Both active: grant the one that is not last_grant.
  - Update last_grant on every grant.
- READ timing:
  - Cycle i+1 after E0 (i = 0..N-1): mem_a = addr+i, mem_wr = 0.
  - Byte i is captured from mem_din in cycle i+2 into bits [8i+7:8i].
  - Done is high in cycle N+2 (word fetch: 5 edges after acceptance). State returns to IDLE at the same edge.
- WRITE timing:
  - Cycle i+1: mem_a = addr+i, mem_dout = wdata[8i+7:8i], mem_wr = 1.
  - Done is high in cycle N+1.
- IO throttle: for a store with IO_BASE <= addr < IO_BASE+8, while io_buffer_full is high:
  - The pending byte is not issued: mem_wr = 0, counter holds.
  - It is issued in the first cycle io_buffer_full is low.
- Idle bus: mem_wr = 0 and mem_a = 0 whenever no transfer is in progress.
- clear:
  - Sampled high during READ: abort, go to IDLE next edge, suppress done, keep partial data internal.
  - WRITE ignores clear (stores are committed).
  - Requests present in the same cycle as clear are not accepted.
- rdy low:
  - All state holds and mem_wr is forced 0.
  - The first byte address driven after rdy returns is re-presented before its capture. The capture is qualified by a registered issued flag that clears whenever rdy is low.
- Read data registers: inst_out and lsb_rdata hold their last value after done. Unused upper bytes of lsb_rdata are 0.
- Misaligned addresses: no check is performed; bytes are transferred at addr+i.

Decomposition:
- Shared package memctrl_pkg holds:
  - the state encoding;
  - the size codes (SZ_B/SZ_H/SZ_W) and the size-to-N function;
  - IO_BASE and the IO window span.
- One natural sub-module: rr_arbiter2. It is the two-way round-robin grant with the last_grant register, the done-cycle mask and the clear gating.

Test Plan:
- RAM[0x100..0x103] = 13 05 00 00; icache fetch 0x100 -> mem_a = 0x100..0x103 in cycles 1–4, memctrl_to_icache high in cycle 6 with inst_out = 0x00000513, then IDLE.
- LSB store half 0xBEEF to 0x204 -> cycle 1 mem_a = 0x204, mem_dout = 0xEF, mem_wr = 1; cycle 2 mem_a = 0x205, mem_dout = 0xBE; done in cycle 3. Reading back a byte from 0x205 returns lsb_rdata = 0x000000BE.
- Both request in the same cycle right after reset -> icache granted first; LSB granted in the first IDLE cycle after the icache done; the next tie goes to the icache.
- clear asserted in cycle 3 of an icache fetch -> no memctrl_to_icache pulse, IDLE next cycle, a pending LSB load accepted right after. A clear during a word store does not stop it: all 4 writes complete and done fires.
- Byte store 0x41 to 0x30000 with io_buffer_full high for 3 cycles -> mem_wr stays 0 for those cycles, then one write of 0x41, then done.
- rdy low for 2 cycles mid word-fetch -> inst_out still equals the correct little-endian word, and done is delayed by exactly the pause plus one re-issue cycle.
